// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared constants for the hazard/stall controller and its MDU busy counter.
package hazard_stall_ctrl_pkg;
  localparam int TNEW_W = 2;
  localparam logic [TNEW_W-1:0] TUSE_NONE = 2'd3;
  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF = 10;
endpackage

// File: rtl/hazard_stall_ctrl_md_busy_counter.sv
// MDU busy tracker: loads the operation latency on start and counts down to idle.
module md_busy_counter
  import hazard_stall_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
  parameter int CNT_W       = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic div,
  output logic busy
);
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);

  logic [CNT_W-1:0] cnt;

  // A start while still counting simply reloads; the stall logic keeps that from happening.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (start) begin
      cnt <= div ? DIV_LOAD : MULT_LOAD;
    end else if (cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign busy = start || (cnt != '0);
endmodule

// File: rtl/hazard_stall_ctrl.sv
// ID/EX stall controller: E/M register hazards plus MDU busy interlock.
// Optional stall statistics counter enabled by defining HAZARD_STATS_EN.
module hazard_stall_ctrl
  import hazard_stall_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
  parameter int CNT_W       = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [4:0]        d_rs,
  input  logic [4:0]        d_rt,
  input  logic [TNEW_W-1:0] d_tuse_rs,
  input  logic [TNEW_W-1:0] d_tuse_rt,
  input  logic              d_is_md,
  input  logic [4:0]        e_a3,
  input  logic              e_we,
  input  logic [TNEW_W-1:0] e_tnew,
  input  logic              e_md_start,
  input  logic              e_md_div,
  input  logic              flush,
  output logic              stall,
  output logic [4:0]        m_a3,
  output logic              m_we,
  output logic [TNEW_W-1:0] m_tnew,
  output logic              md_busy,
  output logic [31:0]       stall_cnt
);
  logic [4:0]        a3_p1;
  logic              we_p1;
  logic [TNEW_W-1:0] tnew_p1;

  function automatic logic [TNEW_W-1:0] tnew_decay(input logic [TNEW_W-1:0] t);
    return (t == '0) ? '0 : t - TNEW_W'(1);
  endfunction

  // A producer blocks a consumer when its result arrives later than the consumer needs it.
  function automatic logic raw_hazard(input logic we, input logic [4:0] a3,
                                      input logic [TNEW_W-1:0] tnew,
                                      input logic [4:0] src,
                                      input logic [TNEW_W-1:0] tuse);
    return we && (a3 != REG_ZERO) && (a3 == src) && (tuse != TUSE_NONE) && (tnew > tuse);
  endfunction

  // ---- E -> M shadow stage (E always advances) ----
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      a3_p1   <= REG_ZERO;
      we_p1   <= 1'b0;
      tnew_p1 <= '0;
    end else begin
      a3_p1   <= e_a3;
      we_p1   <= e_we;
      tnew_p1 <= tnew_decay(e_tnew);
    end
  end

  assign m_a3   = a3_p1;
  assign m_we   = we_p1;
  assign m_tnew = tnew_p1;

  md_busy_counter #(
    .MULT_CYCLES(MULT_CYCLES),
    .DIV_CYCLES (DIV_CYCLES),
    .CNT_W      (CNT_W)
  ) u_md_busy (
    .clk  (clk),
    .reset(reset),
    .start(e_md_start),
    .div  (e_md_div),
    .busy (md_busy)
  );

  always_comb begin
    stall = 1'b0;
    stall = stall | raw_hazard(e_we,  e_a3,  e_tnew,  d_rs, d_tuse_rs);
    stall = stall | raw_hazard(e_we,  e_a3,  e_tnew,  d_rt, d_tuse_rt);
    stall = stall | raw_hazard(we_p1, a3_p1, tnew_p1, d_rs, d_tuse_rs);
    stall = stall | raw_hazard(we_p1, a3_p1, tnew_p1, d_rt, d_tuse_rt);
    stall = stall | (d_is_md && md_busy);
  end

`ifdef HAZARD_STATS_EN
  logic [31:0] stall_cnt_q;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
    end else if (stall) begin
      stall_cnt_q <= sat_inc(stall_cnt_q);
    end
  end

  assign stall_cnt = stall_cnt_q;
`else
  assign stall_cnt = 32'd0;
`endif
endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Self-checking bench for hazard_stall_ctrl: directed scenarios plus randomized traffic vs a reference model.
module tb_hazard_stall_ctrl;
  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  d_rs, d_rt, e_a3;
  logic [1:0]  d_tuse_rs, d_tuse_rt, e_tnew;
  logic        d_is_md, e_we, e_md_start, e_md_div, flush;
  logic        stall, m_we, md_busy;
  logic [4:0]  m_a3;
  logic [1:0]  m_tnew;
  logic [31:0] stall_cnt;

  int n_cmp  = 0;
  int n_fail = 0;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  always #5 clk = ~clk;

  hazard_stall_ctrl dut (
    .clk(clk), .reset(reset), .d_rs(d_rs), .d_rt(d_rt),
    .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt), .d_is_md(d_is_md),
    .e_a3(e_a3), .e_we(e_we), .e_tnew(e_tnew), .e_md_start(e_md_start),
    .e_md_div(e_md_div), .flush(flush), .stall(stall), .m_a3(m_a3),
    .m_we(m_we), .m_tnew(m_tnew), .md_busy(md_busy), .stall_cnt(stall_cnt)
  );

  // Reference model: the instruction that left E last cycle, and the cycle the MDU frees up.
  int  cyc = 0;
  int  mdu_end = -1;
  int  ref_a3 = 0;
  bit  ref_we = 0;
  int  ref_tnew = 0;
  longint ref_stats = 0;

  function automatic bit too_late(bit we, int a3, int tnew, int src, int tuse);
    return we && (a3 != 0) && (a3 == src) && (tnew > tuse);
  endfunction

  function automatic bit ref_busy();
    return e_md_start || (cyc <= mdu_end);
  endfunction

  function automatic bit ref_stall();
    bit s;
    s = too_late(e_we, e_a3, e_tnew, d_rs, d_tuse_rs)
      | too_late(e_we, e_a3, e_tnew, d_rt, d_tuse_rt)
      | too_late(ref_we, ref_a3, ref_tnew, d_rs, d_tuse_rs)
      | too_late(ref_we, ref_a3, ref_tnew, d_rt, d_tuse_rt)
      | (d_is_md && ref_busy());
    return s;
  endfunction

  function automatic longint ref_cnt();
`ifdef HAZARD_STATS_EN
    return ref_stats;
`else
    return 0;
`endif
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      ref_we <= 0; ref_a3 <= 0; ref_tnew <= 0; mdu_end <= -1; ref_stats <= 0;
    end else begin
      if (e_md_start) mdu_end <= cyc + (e_md_div ? DIV_N : MULT_N);
      if (flush) begin
        ref_we <= 0; ref_a3 <= 0; ref_tnew <= 0;
      end else begin
        ref_we <= e_we; ref_a3 <= e_a3; ref_tnew <= (e_tnew > 0) ? e_tnew - 1 : 0;
      end
      if (ref_stall()) ref_stats <= ref_stats + 1;
    end
    cyc <= cyc + 1;
  end

  task automatic set_idle();
    reset = 0; flush = 0; d_rs = 0; d_rt = 0; d_tuse_rs = 3; d_tuse_rt = 3; d_is_md = 0;
    e_a3 = 0; e_we = 0; e_tnew = 0; e_md_start = 0; e_md_div = 0;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk); set_idle();
    end
  endtask

  task automatic test_reset();
    @(negedge clk); set_idle(); reset = 1;
    @(negedge clk); reset = 1;
    @(negedge clk); reset = 0; #1;
    n_cmp++; if (m_a3 !== 5'd0) begin n_fail++; $display("FAIL reset_m_a3 got %0d want 0", m_a3); end
    n_cmp++; if (m_we !== 1'b0) begin n_fail++; $display("FAIL reset_m_we got %b want 0", m_we); end
    n_cmp++; if (m_tnew !== 2'd0) begin n_fail++; $display("FAIL reset_m_tnew got %0d want 0", m_tnew); end
    n_cmp++; if (md_busy !== 1'b0) begin n_fail++; $display("FAIL reset_md_busy got %b want 0", md_busy); end
    n_cmp++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall got %b want 0", stall); end
    n_cmp++; if (stall_cnt !== 32'd0) begin n_fail++; $display("FAIL reset_stall_cnt got %0d want 0", stall_cnt); end
  endtask

  task automatic test_e_producer();
    idle_cycles(2);
    @(negedge clk); e_a3 = 5; e_we = 1; e_tnew = 2; d_rs = 5; d_tuse_rs = 0; #1;
    n_cmp++; if (stall !== 1'b1) begin n_fail++; $display("FAIL e_hazard got %b want 1", stall); end
    @(negedge clk); e_a3 = 0; e_we = 0; e_tnew = 0; #1;
    n_cmp++; if (m_a3 !== 5'd5 || m_tnew !== 2'd1) begin n_fail++; $display("FAIL m_shadow got a3=%0d tnew=%0d want a3=5 tnew=1", m_a3, m_tnew); end
    n_cmp++; if (stall !== 1'b1) begin n_fail++; $display("FAIL m_hazard got %b want 1", stall); end
    @(negedge clk); #1;
    n_cmp++; if (stall !== 1'b0) begin n_fail++; $display("FAIL hazard_resolved got %b want 0", stall); end
  endtask

  task automatic test_reg_zero();
    idle_cycles(2);
    @(negedge clk); e_a3 = 0; e_we = 1; e_tnew = 2; d_rs = 0; d_tuse_rs = 0; #1;
    n_cmp++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reg_zero got %b want 0", stall); end
    @(negedge clk); e_a3 = 7; e_we = 1; e_tnew = 2; d_rs = 0; d_tuse_rs = 3; d_rt = 7; d_tuse_rt = 3; #1;
    n_cmp++; if (stall !== 1'b0) begin n_fail++; $display("FAIL tuse_none got %b want 0", stall); end
  endtask

  task automatic test_forward();
    idle_cycles(2);
    @(negedge clk); e_a3 = 8; e_we = 1; e_tnew = 1; d_rt = 8; d_tuse_rt = 1; #1;
    n_cmp++; if (stall !== 1'b0) begin n_fail++; $display("FAIL forwardable got %b want 0", stall); end
    d_tuse_rt = 0; #1;
    n_cmp++; if (stall !== 1'b1) begin n_fail++; $display("FAIL tuse0_stall got %b want 1", stall); end
  endtask

  task automatic test_mdu(input bit div, input int want);
    int ns, nb;
    idle_cycles(2);
    @(negedge clk); e_md_start = 1; e_md_div = div; d_is_md = 1; #1;
    ns = 0; nb = 0;
    for (int k = 0; k < 20; k++) begin
      if (!stall && !md_busy) break;
      if (stall) ns++;
      if (md_busy) nb++;
      @(negedge clk); e_md_start = 0; #1;
    end
    n_cmp++; if (ns !== want) begin n_fail++; $display("FAIL mdu_stall_len div=%0d got %0d want %0d", div, ns, want); end
    n_cmp++; if (nb !== want) begin n_fail++; $display("FAIL mdu_busy_len div=%0d got %0d want %0d", div, nb, want); end
    idle_cycles(1);
  endtask

  task automatic test_flush();
    idle_cycles(2);
    @(negedge clk); e_a3 = 9; e_we = 1; e_tnew = 2;
    @(negedge clk); e_a3 = 9; e_we = 1; e_tnew = 0; flush = 1; d_rs = 9; d_tuse_rs = 0; #1;
    n_cmp++; if (m_a3 !== 5'd9 || m_tnew !== 2'd1 || m_we !== 1'b1) begin n_fail++; $display("FAIL flush_preload got a3=%0d tnew=%0d we=%b want 9/1/1", m_a3, m_tnew, m_we); end
    n_cmp++; if (stall !== 1'b1) begin n_fail++; $display("FAIL flush_prestall got %b want 1", stall); end
    @(negedge clk); flush = 0; e_a3 = 0; e_we = 0; e_tnew = 0; #1;
    n_cmp++; if (m_we !== 1'b0 || m_a3 !== 5'd0) begin n_fail++; $display("FAIL flush_clear got we=%b a3=%0d want 0/0", m_we, m_a3); end
    n_cmp++; if (stall !== 1'b0) begin n_fail++; $display("FAIL flush_nostall got %b want 0", stall); end
  endtask

  task automatic test_reset_mid_mdu();
    idle_cycles(2);
    @(negedge clk); e_md_start = 1; e_md_div = 1;
    idle_cycles(6);
    @(negedge clk); #1;
    n_cmp++; if (md_busy !== 1'b1) begin n_fail++; $display("FAIL mdu_busy_before_reset got %b want 1", md_busy); end
    reset = 1;
    @(negedge clk); reset = 0; d_is_md = 1; #1;
    n_cmp++; if (md_busy !== 1'b0) begin n_fail++; $display("FAIL mdu_reset got %b want 0", md_busy); end
    n_cmp++; if (stall !== 1'b0) begin n_fail++; $display("FAIL mdu_reset_stall got %b want 0", stall); end
  endtask

  task automatic test_stats();
    longint want;
`ifdef HAZARD_STATS_EN
    want = 3;
`else
    want = 0;
`endif
    @(negedge clk); set_idle(); reset = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); set_idle(); e_a3 = 5; e_we = 1; e_tnew = 2; d_rs = 5; d_tuse_rs = 0;
    end
    idle_cycles(1); #1;
    n_cmp++; if (stall_cnt !== 32'(want)) begin n_fail++; $display("FAIL stats_count got %0d want %0d", stall_cnt, want); end
    @(negedge clk); reset = 1;
    @(negedge clk); reset = 0; #1;
    n_cmp++; if (stall_cnt !== 32'd0) begin n_fail++; $display("FAIL stats_reset got %0d want 0", stall_cnt); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      reset      = ($urandom_range(0, 49) == 0);
      flush      = ($urandom_range(0, 15) == 0);
      d_rs       = 5'($urandom_range(0, 3));
      d_rt       = 5'($urandom_range(0, 3));
      d_tuse_rs  = 2'($urandom_range(0, 3));
      d_tuse_rt  = 2'($urandom_range(0, 3));
      d_is_md    = ($urandom_range(0, 3) == 0);
      e_a3       = 5'($urandom_range(0, 3));
      e_we       = 1'($urandom_range(0, 1));
      e_tnew     = 2'($urandom_range(0, 2));
      e_md_start = (cyc > mdu_end) && ($urandom_range(0, 7) == 0);
      e_md_div   = 1'($urandom_range(0, 1));
      #1;
      n_cmp++; if (stall !== ref_stall()) begin n_fail++; $display("FAIL rnd_stall cyc=%0d got %b want %b", cyc, stall, ref_stall()); end
      n_cmp++; if (md_busy !== ref_busy()) begin n_fail++; $display("FAIL rnd_md_busy cyc=%0d got %b want %b", cyc, md_busy, ref_busy()); end
      n_cmp++; if (m_a3 !== 5'(ref_a3) || m_we !== ref_we || m_tnew !== 2'(ref_tnew)) begin
        n_fail++; $display("FAIL rnd_shadow cyc=%0d got %0d/%b/%0d want %0d/%b/%0d", cyc, m_a3, m_we, m_tnew, ref_a3, ref_we, ref_tnew);
      end
      n_cmp++; if (stall_cnt !== 32'(ref_cnt())) begin n_fail++; $display("FAIL rnd_stall_cnt cyc=%0d got %0d want %0d", cyc, stall_cnt, ref_cnt()); end
    end
  endtask

  initial begin
    set_idle();
    reset = 1;
    test_reset();
    test_e_producer();
    test_reg_zero();
    test_forward();
    test_mdu(1'b1, DIV_N + 1);
    test_mdu(1'b0, MULT_N + 1);
    test_flush();
    test_reset_mid_mdu();
    test_stats();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout bench did not finish within time limit");
    $fatal(1, "timeout");
  end
endmodule
